// File: rtl/fp_multiplier.sv
// IEEE-754 single-precision multiplier: sequential radix-2 shift-add core with
// one-edge special-case bypass, round-to-nearest-even, and flush-to-zero.
module fp_multiplier #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] op_a,
  input  logic [width-1:0] op_b,
  output logic             busy,
  output logic             valid,
  output logic [width-1:0] product
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UNPACK    = 3'd1,
    MULTIPLY  = 3'd2,
    NORMALIZE = 3'd3,
    ROUND     = 3'd4
  } state_t;

  state_t             state_q;
  logic [31:0]        a_q, b_q;
  logic [23:0]        ma_q, mb_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [47:0]        acc_q;
  logic [4:0]         cnt_q;
  logic [22:0]        mant_q;
  logic               guard_q, sticky_q;
  logic               busy_q, valid_q;
  logic [31:0]        product_q;

  logic               special_hit_d;
  logic [31:0]        special_product_d;
  logic [47:0]        partial_d;
  logic [22:0]        norm_mant_d;
  logic               norm_guard_d, norm_sticky_d;
  logic signed [9:0]  norm_exp_d;
  logic               round_inc_d;
  logic [23:0]        round_sum_d;
  logic signed [9:0]  round_exp_d;
  logic [31:0]        round_product_d;

  // Exponent 0 covers both zero and subnormal, which are flushed to signed zero.
  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  // Special-operand decode, evaluated on the live inputs while idle
  always_comb begin
    special_hit_d = is_zero(op_a) | is_zero(op_b) | (op_a[30:23] == 8'hFF) | (op_b[30:23] == 8'hFF);
    if (is_nan(op_a) || is_nan(op_b) || (is_inf(op_a) && is_zero(op_b)) || (is_inf(op_b) && is_zero(op_a))) begin
      special_product_d = 32'h7FC0_0000;
    end else if (is_inf(op_a) || is_inf(op_b)) begin
      special_product_d = {op_a[31] ^ op_b[31], 8'hFF, 23'h0};
    end else if (is_zero(op_a) || is_zero(op_b)) begin
      special_product_d = {op_a[31] ^ op_b[31], 31'h0};
    end else begin
      special_product_d = 32'h0;
    end
  end

  // Partial product for the current multiplier bit
  always_comb begin
    if (mb_q[cnt_q]) begin
      partial_d = {24'd0, ma_q} << cnt_q;
    end else begin
      partial_d = 48'd0;
    end
  end

  // Normalization selects the 23 bits below the leading one of the 48-bit product
  always_comb begin
    if (acc_q[47]) begin
      norm_mant_d   = acc_q[46:24];
      norm_guard_d  = acc_q[23];
      norm_sticky_d = |acc_q[22:0];
      norm_exp_d    = exp_q + 10'sd1;
    end else begin
      norm_mant_d   = acc_q[45:23];
      norm_guard_d  = acc_q[22];
      norm_sticky_d = |acc_q[21:0];
      norm_exp_d    = exp_q;
    end
  end

  // Round to nearest even; a mantissa carry-out leaves round_sum_d[22:0] at zero
  always_comb begin
    round_inc_d = guard_q & (sticky_q | mant_q[0]);
    round_sum_d = {1'b0, mant_q} + {23'd0, round_inc_d};
    round_exp_d = exp_q + $signed({9'd0, round_sum_d[23]});
    if (round_exp_d >= 10'sd255) begin
      round_product_d = {sign_q, 8'hFF, 23'h0};
    end else if (round_exp_d <= 10'sd0) begin
      round_product_d = {sign_q, 31'h0};
    end else begin
      round_product_d = {sign_q, round_exp_d[7:0], round_sum_d[22:0]};
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      ma_q      <= 24'd0;
      mb_q      <= 24'd0;
      sign_q    <= 1'b0;
      exp_q     <= 10'sd0;
      acc_q     <= 48'd0;
      cnt_q     <= 5'd0;
      mant_q    <= 23'd0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      product_q <= 32'd0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (special_hit_d) begin
              product_q <= special_product_d;
              valid_q   <= 1'b1;
            end else begin
              a_q     <= op_a;
              b_q     <= op_b;
              busy_q  <= 1'b1;
              state_q <= UNPACK;
            end
          end
        end
        UNPACK: begin
          ma_q    <= {1'b1, a_q[22:0]};
          mb_q    <= {1'b1, b_q[22:0]};
          sign_q  <= a_q[31] ^ b_q[31];
          exp_q   <= $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'sd127;
          acc_q   <= 48'd0;
          cnt_q   <= 5'd0;
          state_q <= MULTIPLY;
        end
        MULTIPLY: begin
          acc_q <= acc_q + partial_d;
          if (cnt_q == 5'd23) begin
            cnt_q   <= 5'd0;
            state_q <= NORMALIZE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        NORMALIZE: begin
          mant_q   <= norm_mant_d;
          guard_q  <= norm_guard_d;
          sticky_q <= norm_sticky_d;
          exp_q    <= norm_exp_d;
          state_q  <= ROUND;
        end
        ROUND: begin
          product_q <= round_product_d;
          valid_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign product = product_q;

endmodule

// File: tb/tb_fp_multiplier.sv
// Self-checking bench for fp_multiplier: arithmetic reference model plus a
// cycle-level timing model, directed spec vectors and randomized operands.
module tb_fp_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, valid;
  logic [31:0] product;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  logic        m_busy, m_valid;
  logic [31:0] m_product, m_res;
  int          m_cnt;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    int          lat;
  } vec_t;

  vec_t vecs[10] = '{
    '{32'h3FC00000, 32'h40000000, 32'h40400000, 28},
    '{32'h3F800001, 32'h3F800001, 32'h3F800002, 28},
    '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 28},
    '{32'hBF800000, 32'h3F800000, 32'hBF800000, 28},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1},
    '{32'hFF800000, 32'h40000000, 32'hFF800000, 1},
    '{32'h00000000, 32'hC0000000, 32'h80000000, 1},
    '{32'h7F000000, 32'h40000000, 32'h7F800000, 28},
    '{32'h00800000, 32'h00800000, 32'h00000000, 28},
    '{32'h00000001, 32'h3F800000, 32'h00000000, 1}
  };

  logic [31:0] specials[8] = '{32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'hFFFFFFFF,
                               32'h00000000, 32'h80000000, 32'h00000005, 32'h3F800000};

  fp_multiplier #(.width(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .valid  (valid),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) || (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  // Reference product from exact integer multiplication and explicit RNE
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    bit          az, bz, ai, bi, an, bn;
    logic [63:0] p, q, rem, half;
    int          e, sh;
    s  = a[31] ^ b[31];
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
    if (ai || bi) return {s, 8'hFF, 23'h0};
    if (az || bz) return {s, 31'h0};
    p = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  // Timing model: specials answer on the start edge, normal ops on edge 28
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    <= 1'b0;
      m_valid   <= 1'b0;
      m_product <= 32'd0;
      m_res     <= 32'd0;
      m_cnt     <= 0;
    end else begin
      m_valid <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          if (is_special(op_a, op_b)) begin
            m_product <= ref_mul(op_a, op_b);
            m_valid   <= 1'b1;
          end else begin
            m_busy <= 1'b1;
            m_cnt  <= 1;
            m_res  <= ref_mul(op_a, op_b);
          end
        end
      end else if (m_cnt == 27) begin
        m_busy    <= 1'b0;
        m_valid   <= 1'b1;
        m_product <= m_res;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      check("cyc_valid", {31'd0, valid}, {31'd0, m_valid});
      check("cyc_product", product, m_product);
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_p,
                       input int exp_lat, input int poke_edge, input string name);
    int lat;
    lat = 0;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #2;
      start = 1'b0;
      op_a  = $urandom;
      op_b  = $urandom;
      if (i == 1) check({name, "_busy_e1"}, {31'd0, busy}, {31'd0, exp_lat == 28});
      if (valid) begin
        lat = i;
        break;
      end
      if (i == poke_edge - 1) begin
        start = 1'b1;
        op_a  = 32'h7F800000;
        op_b  = 32'h00000000;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_product"}, product, exp_p);
  endtask

  initial begin
    int          vcount;
    logic [31:0] a, b;
    logic [7:0]  ea, eb;
    rst   = 1'b0;
    start = 1'b0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_product", product, 32'd0);
    cmp_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      check($sformatf("model_pin%0d", i), ref_mul(vecs[i].a, vecs[i].b), vecs[i].p);
      do_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat, 0, $sformatf("vec%0d", i));
    end

    do_op(32'h3FC00000, 32'h40000000, 32'h40400000, 28, 10, "poke_e10");

    // Abort mid-operation with an asynchronous reset shortly before edge 15
    @(negedge clk);
    op_a  = 32'h3FFFFFFF;
    op_b  = 32'h3FFFFFFF;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (13) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_product", product, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(32'h3FC00000, 32'h40000000, 32'h40400000, 28, 0, "after_abort");

    // Held start relaunches on every completion: starts at edges 1, 29, 57
    @(negedge clk);
    op_a   = 32'h40490FDB;
    op_b   = 32'hC02DF854;
    start  = 1'b1;
    vcount = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #2;
      if (valid) vcount++;
    end
    start = 1'b0;
    check("held_start_valids", 32'(vcount), 32'd2);
    repeat (30) @(posedge clk);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0: begin
          a = $urandom;
          b = $urandom;
        end
        1: begin
          a = specials[$urandom_range(0, 7)];
          b = (($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 7)] : 32'($urandom));
        end
        default: begin
          ea = 8'($urandom_range(64, 190));
          eb = 8'($urandom_range(64, 190));
          a  = {1'($urandom_range(0, 1)), ea, 23'($urandom)};
          b  = {1'($urandom_range(0, 1)), eb, 23'($urandom)};
        end
      endcase
      do_op(a, b, ref_mul(a, b), is_special(a, b) ? 1 : 28, 0, "rand");
    end

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
